vga_layer_pipe: RTL and testbench

//  Pipelined, parametrised sprite-layer compositor for the VGA path. Sits between the per-sprite

---
 rtl/vga_layer_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_vga_layer_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_pipe.sv
// Sprite-layer compositor: a registered radix-4 priority tree picks the lowest-index opaque layer,
// with matched sideband delay, RGB565 expansion and per-frame collision counting.
module vga_layer_pipe #(
    parameter int unsigned LAYERS = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                                         CLK,
    input  logic                                         RESET_N,
    input  logic                                         VGA_IN_VALID,
    input  logic                                         VGA_IN_HS,
    input  logic                                         VGA_IN_VS,
    input  logic                                         VGA_FRAME_START,
    input  logic [LAYERS-1:0]                            VGA_SPRITE_ISOBJ,
    input  logic [LAYERS-1:0][15:0]                      VGA_SPRITE_PIXEL,
    input  logic [15:0]                                  VGA_VAL,
    input  logic [LAYERS-1:0]                            LAYER_EN,
    input  logic                                         KEY_EN,
    input  logic [15:0]                                  KEY_COLOR,
    output logic [7:0]                                   VGA_R,
    output logic [7:0]                                   VGA_G,
    output logic [7:0]                                   VGA_B,
    output logic                                         VGA_OUT_VALID,
    output logic                                         VGA_OUT_HS,
    output logic                                         VGA_OUT_VS,
    output logic                                         VGA_OUT_HIT,
    output logic [((LAYERS > 1) ? $clog2(LAYERS) : 1)-1:0] VGA_OUT_LAYER,
    output logic                                         COLLISION_FLAG,
    output logic [CNT_W-1:0]                             COLLISION_CNT
);

    localparam int unsigned LOG2   = $clog2(LAYERS);
    localparam int unsigned STAGES = (LOG2 <= 2) ? 1 : (LOG2 + 1) / 2;
    localparam int unsigned NLEAF  = 1 << (2 * STAGES);
    localparam int unsigned NODES  = (NLEAF - 1) / 3;
    localparam int unsigned TOTAL  = NLEAF + NODES;
    localparam int unsigned IDX_W  = 2 * STAGES;
    localparam int unsigned LW     = (LAYERS > 1) ? LOG2 : 1;

    // Flat node numbering: leaves first, then each tree level in turn; root is the last entry.
    function automatic int unsigned lvl_base(input int unsigned k);
        int unsigned s;
        s = 0;
        for (int unsigned m = 0; m < k; m++) s += 1 << (2 * (STAGES - m));
        return s;
    endfunction

    logic [NODES-1:0]             r_hit;
    logic [NODES-1:0]             r_multi;
    logic [NODES-1:0][15:0]       r_pix;
    logic [NODES-1:0][IDX_W-1:0]  r_idx;

    logic [NODES-1:0]             w_nxt_hit;
    logic [NODES-1:0]             w_nxt_multi;
    logic [NODES-1:0][15:0]       w_nxt_pix;
    logic [NODES-1:0][IDX_W-1:0]  w_nxt_idx;

    logic [TOTAL-1:0]             w_src_hit;
    logic [TOTAL-1:0]             w_src_multi;
    logic [TOTAL-1:0][15:0]       w_src_pix;
    logic [TOTAL-1:0][IDX_W-1:0]  w_src_idx;

    logic [STAGES-1:0]            r_dvalid;
    logic [STAGES-1:0]            r_dhs;
    logic [STAGES-1:0]            r_dvs;
    logic [STAGES-1:0]            r_dfs;
    logic [STAGES-1:0][15:0]      r_dval;
    logic [CNT_W-1:0]             r_run;

    logic                         w_fvalid;
    logic                         w_root_hit;
    logic                         w_coll;
    logic [15:0]                  w_col;

    always_comb begin
        w_src_hit   = '0;
        w_src_multi = '0;
        w_src_pix   = '0;
        w_src_idx   = '0;
        for (int unsigned i = 0; i < LAYERS; i++) begin
            w_src_hit[i] = VGA_SPRITE_ISOBJ[i] & LAYER_EN[i]
                         & ~(KEY_EN & (VGA_SPRITE_PIXEL[i] == KEY_COLOR));
            w_src_pix[i] = VGA_SPRITE_PIXEL[i];
        end
        for (int unsigned i = 0; i < NLEAF; i++) w_src_idx[i] = IDX_W'(i);
        for (int unsigned n = 0; n < NODES; n++) begin
            w_src_hit[NLEAF+n]   = r_hit[n];
            w_src_multi[NLEAF+n] = r_multi[n];
            w_src_pix[NLEAF+n]   = r_pix[n];
            w_src_idx[NLEAF+n]   = r_idx[n];
        end
    end

    always_comb begin
        logic        t_found;
        logic        t_multi;
        logic [2:0]  t_nhit;
        logic [15:0] t_pix;
        logic [IDX_W-1:0] t_idx;
        int unsigned src;
        int unsigned dst;
        w_nxt_hit   = '0;
        w_nxt_multi = '0;
        w_nxt_pix   = '0;
        w_nxt_idx   = '0;
        t_found = 1'b0;
        t_multi = 1'b0;
        t_nhit  = '0;
        t_pix   = '0;
        t_idx   = '0;
        src     = 0;
        dst     = 0;
        for (int unsigned k = 1; k <= STAGES; k++) begin
            for (int unsigned j = 0; j < (32'd1 << (2 * (STAGES - k))); j++) begin
                t_found = 1'b0;
                t_multi = 1'b0;
                t_nhit  = '0;
                t_pix   = '0;
                t_idx   = '0;
                for (int unsigned c = 0; c < 4; c++) begin
                    src     = lvl_base(k - 1) + 4 * j + c;
                    t_nhit  = t_nhit + 3'(w_src_hit[src]);
                    t_multi = t_multi | w_src_multi[src];
                    if (w_src_hit[src] && !t_found) begin
                        t_pix = w_src_pix[src];
                        t_idx = w_src_idx[src];
                    end
                    t_found = t_found | w_src_hit[src];
                end
                dst              = lvl_base(k) - NLEAF + j;
                w_nxt_hit[dst]   = t_found;
                w_nxt_multi[dst] = t_multi | (t_nhit >= 3'd2);
                w_nxt_pix[dst]   = t_pix;
                w_nxt_idx[dst]   = t_idx;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_hit    <= '0;
            r_multi  <= '0;
            r_pix    <= '0;
            r_idx    <= '0;
            r_dvalid <= '0;
            r_dhs    <= '0;
            r_dvs    <= '0;
            r_dfs    <= '0;
            r_dval   <= '0;
        end else begin
            r_hit       <= w_nxt_hit;
            r_multi     <= w_nxt_multi;
            r_pix       <= w_nxt_pix;
            r_idx       <= w_nxt_idx;
            r_dvalid[0] <= VGA_IN_VALID;
            r_dhs[0]    <= VGA_IN_HS;
            r_dvs[0]    <= VGA_IN_VS;
            r_dfs[0]    <= VGA_FRAME_START;
            r_dval[0]   <= VGA_VAL;
            for (int unsigned s = 1; s < STAGES; s++) begin
                r_dvalid[s] <= r_dvalid[s-1];
                r_dhs[s]    <= r_dhs[s-1];
                r_dvs[s]    <= r_dvs[s-1];
                r_dfs[s]    <= r_dfs[s-1];
                r_dval[s]   <= r_dval[s-1];
            end
        end
    end

    assign w_fvalid   = r_dvalid[STAGES-1];
    assign w_root_hit = w_src_hit[TOTAL-1];
    assign w_col      = w_root_hit ? w_src_pix[TOTAL-1] : r_dval[STAGES-1];
    assign w_coll     = w_fvalid & w_src_multi[TOTAL-1];

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            VGA_R          <= '0;
            VGA_G          <= '0;
            VGA_B          <= '0;
            VGA_OUT_VALID  <= 1'b0;
            VGA_OUT_HS     <= 1'b0;
            VGA_OUT_VS     <= 1'b0;
            VGA_OUT_HIT    <= 1'b0;
            VGA_OUT_LAYER  <= '0;
            COLLISION_FLAG <= 1'b0;
        end else begin
            VGA_R          <= w_fvalid ? {w_col[4:0], w_col[4:2]}     : 8'h00;
            VGA_G          <= w_fvalid ? {w_col[10:5], w_col[10:9]}   : 8'h00;
            VGA_B          <= w_fvalid ? {w_col[15:11], w_col[15:13]} : 8'h00;
            VGA_OUT_VALID  <= w_fvalid;
            VGA_OUT_HS     <= r_dhs[STAGES-1];
            VGA_OUT_VS     <= r_dvs[STAGES-1];
            VGA_OUT_HIT    <= w_fvalid & w_root_hit;
            VGA_OUT_LAYER  <= (w_fvalid & w_root_hit) ? LW'(w_src_idx[TOTAL-1]) : '0;
            COLLISION_FLAG <= w_coll;
        end
    end

    // The frame-start pixel's own collision opens the new frame's count.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_run         <= '0;
            COLLISION_CNT <= '0;
        end else if (r_dfs[STAGES-1]) begin
            COLLISION_CNT <= r_run;
            r_run         <= CNT_W'(w_coll);
        end else if (w_coll && (r_run != '1)) begin
            r_run <= r_run + 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_layer_pipe.sv
// Bench for vga_layer_pipe: 64-layer and 5-layer/4-bit-counter instances checked against a
// per-pixel reference model delayed by each instance's latency.
module tb_vga_layer_pipe;

    localparam int unsigned LA = 4;
    localparam int unsigned LB = 3;

    typedef struct packed {
        logic       valid;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       hit;
        logic       flag;
        logic [5:0] layer;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } px_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic              RESET_N;
    logic              s_valid, s_hs, s_vs, s_fs, s_key_en;
    logic [63:0]       s_isobj, s_en;
    logic [63:0][15:0] s_pix;
    logic [15:0]       s_vval, s_key;

    logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic        a_valid, a_hs, a_vs, a_hit, a_flag;
    logic        b_valid, b_hs, b_vs, b_hit, b_flag;
    logic [5:0]  a_layer;
    logic [2:0]  b_layer;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    vga_layer_pipe #(.LAYERS(64), .CNT_W(16)) u_a (
        .CLK(CLK), .RESET_N(RESET_N), .VGA_IN_VALID(s_valid), .VGA_IN_HS(s_hs), .VGA_IN_VS(s_vs),
        .VGA_FRAME_START(s_fs), .VGA_SPRITE_ISOBJ(s_isobj), .VGA_SPRITE_PIXEL(s_pix),
        .VGA_VAL(s_vval), .LAYER_EN(s_en), .KEY_EN(s_key_en), .KEY_COLOR(s_key),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .VGA_OUT_VALID(a_valid), .VGA_OUT_HS(a_hs),
        .VGA_OUT_VS(a_vs), .VGA_OUT_HIT(a_hit), .VGA_OUT_LAYER(a_layer),
        .COLLISION_FLAG(a_flag), .COLLISION_CNT(a_cnt)
    );

    vga_layer_pipe #(.LAYERS(5), .CNT_W(4)) u_b (
        .CLK(CLK), .RESET_N(RESET_N), .VGA_IN_VALID(s_valid), .VGA_IN_HS(s_hs), .VGA_IN_VS(s_vs),
        .VGA_FRAME_START(s_fs), .VGA_SPRITE_ISOBJ(s_isobj[4:0]), .VGA_SPRITE_PIXEL(s_pix[4:0]),
        .VGA_VAL(s_vval), .LAYER_EN(s_en[4:0]), .KEY_EN(s_key_en), .KEY_COLOR(s_key),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_OUT_VALID(b_valid), .VGA_OUT_HS(b_hs),
        .VGA_OUT_VS(b_vs), .VGA_OUT_HIT(b_hit), .VGA_OUT_LAYER(b_layer),
        .COLLISION_FLAG(b_flag), .COLLISION_CNT(b_cnt)
    );

    px_t         pa [LA];
    px_t         pb [LB];
    int unsigned run_a, cnt_a, run_b, cnt_b;
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;

    // Expected output for the pixel currently on the inputs, considering the first n layers.
    function automatic px_t calc(input int unsigned n);
        px_t         e;
        int unsigned hits;
        int          first;
        logic [15:0] c;
        int unsigned v;
        hits  = 0;
        first = -1;
        for (int unsigned i = 0; i < n; i++) begin
            if (s_isobj[i] && s_en[i] && !(s_key_en && (s_pix[i] == s_key))) begin
                if (first < 0) first = int'(i);
                hits++;
            end
        end
        c       = (first >= 0) ? s_pix[first] : s_vval;
        e       = '0;
        e.valid = s_valid;
        e.hs    = s_hs;
        e.vs    = s_vs;
        e.fs    = s_fs;
        if (s_valid) begin
            v       = 32'(c) % 32;
            e.r     = 8'(v * 8 + v / 4);
            v       = (32'(c) / 32) % 64;
            e.g     = 8'(v * 4 + v / 16);
            v       = 32'(c) / 2048;
            e.b     = 8'(v * 8 + v / 4);
            e.hit   = (first >= 0);
            e.layer = (first >= 0) ? 6'(first) : 6'd0;
            e.flag  = (hits >= 2);
        end
        return e;
    endfunction

    function automatic px_t nofs(input px_t p);
        px_t q;
        q    = p;
        q.fs = 1'b0;
        return q;
    endfunction

    function automatic px_t obs_a();
        px_t o;
        o       = '0;
        o.valid = a_valid; o.hs = a_hs; o.vs = a_vs; o.hit = a_hit; o.flag = a_flag;
        o.layer = a_layer; o.r = a_r; o.g = a_g; o.b = a_b;
        return o;
    endfunction

    function automatic px_t obs_b();
        px_t o;
        o       = '0;
        o.valid = b_valid; o.hs = b_hs; o.vs = b_vs; o.hit = b_hit; o.flag = b_flag;
        o.layer = {3'b000, b_layer}; o.r = b_r; o.g = b_g; o.b = b_b;
        return o;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        px_t ea, eb;
        @(posedge CLK);
        ea = calc(64);
        eb = calc(5);
        if (!RESET_N) begin
            for (int unsigned i = 0; i < LA; i++) pa[i] = '0;
            for (int unsigned i = 0; i < LB; i++) pb[i] = '0;
            run_a = 0; cnt_a = 0; run_b = 0; cnt_b = 0;
        end else begin
            for (int unsigned i = LA - 1; i > 0; i--) pa[i] = pa[i-1];
            for (int unsigned i = LB - 1; i > 0; i--) pb[i] = pb[i-1];
            pa[0] = ea;
            pb[0] = eb;
            if (pa[LA-1].fs) begin
                cnt_a = run_a;
                run_a = 32'(pa[LA-1].flag);
            end else if (pa[LA-1].flag && run_a < 65535) run_a++;
            if (pb[LB-1].fs) begin
                cnt_b = run_b;
                run_b = 32'(pb[LB-1].flag);
            end else if (pb[LB-1].flag && run_b < 15) run_b++;
        end
        #1;
        check("pix_a", 64'(obs_a()), 64'(nofs(pa[LA-1])));
        check("cnt_a", 64'(a_cnt), 64'(cnt_a));
        check("pix_b", 64'(obs_b()), 64'(nofs(pb[LB-1])));
        check("cnt_b", 64'(b_cnt), 64'(cnt_b));
    endtask

    task automatic idle_in();
        s_valid = 1'b0; s_hs = 1'b0; s_vs = 1'b0; s_fs = 1'b0;
        s_key_en = 1'b0; s_key = '0; s_isobj = '0; s_en = '1; s_pix = '0; s_vval = '0;
    endtask

    initial begin
        RESET_N = 1'b0;
        idle_in();
        repeat (3) tick();
        check("rst_a", 64'({a_r, a_g, a_b, a_valid, a_hs, a_vs, a_hit, a_layer, a_flag, a_cnt}), 64'd0);
        RESET_N = 1'b1;

        s_valid = 1'b1; s_isobj[5] = 1'b1; s_isobj[9] = 1'b1; s_pix[5] = 16'hF800;
        repeat (LA) tick();
        check("t1_b", 64'(a_b), 64'hFF);
        check("t1_rg", 64'({a_r, a_g}), 64'd0);
        check("t1_layer", 64'(a_layer), 64'd5);
        check("t1_hit", 64'(a_hit), 64'd1);
        check("t1_flag", 64'(a_flag), 64'd1);

        idle_in(); s_valid = 1'b1; s_vval = 16'h001F;
        repeat (LA) tick();
        check("t2_r", 64'(a_r), 64'hFF);
        check("t2_gb", 64'({a_g, a_b}), 64'd0);
        check("t2_hit_layer", 64'({a_hit, a_layer}), 64'd0);
        s_valid = 1'b0;
        repeat (LA) tick();
        check("t2_blank", 64'({a_r, a_g, a_b}), 64'd0);

        idle_in(); s_valid = 1'b1;
        s_isobj[0] = 1'b1; s_pix[0] = 16'h07E0; s_key = 16'h07E0; s_key_en = 1'b1;
        s_isobj[63] = 1'b1; s_pix[63] = 16'h001F;
        repeat (LA) tick();
        check("t3_key_layer", 64'(a_layer), 64'd63);
        check("t3_key_flag", 64'(a_flag), 64'd0);
        s_key_en = 1'b0;
        repeat (LA) tick();
        check("t3_nokey_layer", 64'(a_layer), 64'd0);
        check("t3_nokey_g", 64'(a_g), 64'hFF);

        idle_in(); s_valid = 1'b1; s_isobj = 64'h3; s_en[0] = 1'b0;
        repeat (LA) tick();
        check("t4_layer", 64'(a_layer), 64'd1);
        check("t4_flag", 64'(a_flag), 64'd0);

        idle_in(); s_valid = 1'b1; s_isobj = 64'h2; s_fs = 1'b1;
        tick();
        s_fs = 1'b0;
        for (int i = 0; i < 37; i++) begin
            s_isobj = 64'hA; tick();
            s_isobj = 64'h2; tick();
        end
        s_valid = 1'b0; s_isobj = 64'hA;
        repeat (5) tick();
        s_valid = 1'b1; s_isobj = 64'h2; s_fs = 1'b1;
        tick();
        s_fs = 1'b0;
        repeat (LA - 1) tick();
        check("t5_cnt37_a", 64'(a_cnt), 64'd37);
        check("t5_sat_b", 64'(b_cnt), 64'd15);
        s_isobj = 64'hA;
        repeat (20) tick();
        s_isobj = 64'h2; s_fs = 1'b1;
        tick();
        s_fs = 1'b0;
        repeat (LA - 1) tick();
        check("t5_cnt20_a", 64'(a_cnt), 64'd20);
        check("t5_sat20_b", 64'(b_cnt), 64'd15);

        for (int i = 0; i < 300; i++) begin
            RESET_N  = !(i == 150 || i == 151);
            s_valid  = (i >= 152 && i <= 155) ? 1'b1 : ($urandom_range(0, 4) != 0);
            s_hs     = 1'($urandom);
            s_vs     = 1'($urandom);
            s_fs     = ($urandom_range(0, 39) == 0);
            s_key_en = 1'($urandom);
            s_key    = 16'($urandom);
            s_vval   = 16'($urandom);
            s_en     = {$urandom, $urandom} | {$urandom, $urandom};
            if ($urandom_range(0, 1) != 0) s_isobj = {$urandom, $urandom} & {$urandom, $urandom};
            else s_isobj = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            for (int j = 0; j < 64; j++) s_pix[j] = ($urandom_range(0, 3) == 0) ? s_key : 16'($urandom);
            tick();
            if (i == 150)
                check("rst_mid", 64'({a_valid, a_hit, a_flag, a_r, a_g, a_b, a_layer, a_cnt}), 64'd0);
            if (i >= 152 && i <= 154) check("rel_hold", 64'(a_valid), 64'd0);
            if (i == 155) check("rel_first", 64'(a_valid), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
